// File: rtl/knn_pkg.sv
// Shared constants, FSM state type and the word-count saturation helper
// for the local search-point buffer controller.
package knn_pkg;

    localparam int DataWidth    = 256;
    localparam int AddressRange = 2048;
    localparam int AddressWidth = 11;
    // One extra bit so that a full-buffer count (AddressRange) is representable
    localparam int CountWidth   = AddressWidth + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    // Requested word counts beyond the buffer depth are clamped to the depth
    function automatic logic [CountWidth-1:0] sat_words(input logic [CountWidth-1:0] words);
        return (words > CountWidth'(AddressRange)) ? CountWidth'(AddressRange) : words;
    endfunction

endpackage

// File: rtl/knn_sync_fifo.sv
// Small synchronous show-ahead FIFO used as the output skid buffer.
// The head word is presented combinationally and forced to zero when empty.
module knn_sync_fifo #(
    parameter int Width = 256,
    parameter int Depth = 4,
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [Width-1:0]    push_data,
    input  logic                pop,
    output logic [Width-1:0]    pop_data,
    output logic [CntWidth-1:0] count
);

    logic [Width-1:0]    store_reg [Depth];
    logic [PtrWidth-1:0] wr_ptr_reg;
    logic [PtrWidth-1:0] rd_ptr_reg;
    logic [CntWidth-1:0] count_reg;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign pop_ok   = pop && (count_reg != '0);
    assign push_ok  = push && ((count_reg != CntWidth'(Depth)) || pop_ok);
    assign pop_data = (count_reg != '0) ? store_reg[rd_ptr_reg] : '0;
    assign count    = count_reg;

    // Storage array: written on push, no reset needed since reads are gated by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CntWidth'(1);
                2'b01:   count_reg <= count_reg - CntWidth'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/knn_local_sp_stream_ctrl.sv
// Controller for the single-port local search-point buffer: loads a word
// stream into addresses 0..N-1, then streams the buffer back a number of
// passes through a credit-limited skid FIFO.
module knn_local_sp_stream_ctrl
    import knn_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth:0]   num_words,
    input  logic [15:0]             num_passes,
    output logic                    busy,
    output logic                    done,
    input  logic [DataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AddressWidth-1:0] mem_address0,
    output logic                    mem_ce0,
    output logic                    mem_we0,
    output logic [DataWidth-1:0]    mem_d0,
    input  logic [DataWidth-1:0]    mem_q0
);

    localparam int FillWidth = $clog2(FIFO_DEPTH + 1);

    state_t                  state_reg, state_next;
    logic [CountWidth-1:0]   n_reg, wr_cnt_reg, n_last, n_sat;
    logic [15:0]             passes_reg, rd_pass_reg, pop_pass_reg, passes_last;
    logic [AddressWidth-1:0] rd_addr_reg, pop_idx_reg;
    logic [FillWidth-1:0]    outstanding_reg, fifo_count;
    logic [READ_LATENCY:0]   rd_vld;
    logic                    start_ok, wr_fire, wr_last, reads_left, credit_ok, rd_fire;
    logic                    rd_wrap, pop_wrap, push, pop, pop_last;

    assign n_sat       = sat_words(num_words);
    assign n_last      = n_reg - CountWidth'(1);
    assign passes_last = passes_reg - 16'd1;
    assign start_ok    = (state_reg == IDLE) && start;
    assign wr_fire     = in_valid && in_ready;
    assign wr_last     = wr_fire && (wr_cnt_reg == n_last);
    assign reads_left  = rd_pass_reg < passes_reg;
    // Words already in the FIFO plus reads still in flight must fit in the FIFO
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < (FillWidth + 1)'(FIFO_DEPTH);
    assign rd_fire     = (state_reg == DRAIN) && reads_left && credit_ok;
    assign rd_wrap     = ({1'b0, rd_addr_reg} == n_last);
    assign pop_wrap    = ({1'b0, pop_idx_reg} == n_last);
    assign push        = rd_vld[READ_LATENCY];
    assign pop         = out_valid && out_ready;
    assign pop_last    = pop && pop_wrap && (pop_pass_reg == passes_last);
    assign out_valid   = (fifo_count != '0);

    // Read-data valid pipeline: stage 0 is the read command currently on the bus
    assign rd_vld[0] = mem_ce0 && !mem_we0;
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_rd_vld
            logic stage_reg;
            // Delay the read-command flag by one more cycle; reset drops in-flight data
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= rd_vld[gi];
                end
            end
            assign rd_vld[gi + 1] = stage_reg;
        end
    endgenerate

    knn_sync_fifo #(
        .Width (DataWidth),
        .Depth (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_q0),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (n_sat == '0) ? DONE : LOAD;
            LOAD:    if (wr_last) state_next = DRAIN;
            DRAIN:   if (pop_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
        case (state_reg)
            LOAD: begin
                busy     = 1'b1;
                in_ready = (wr_cnt_reg < n_reg);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Job parameters, address counters, credit tracking and registered buffer port
    always_ff @(posedge clk) begin
        if (reset) begin
            n_reg           <= '0;
            passes_reg      <= '0;
            wr_cnt_reg      <= '0;
            rd_addr_reg     <= '0;
            rd_pass_reg     <= '0;
            pop_idx_reg     <= '0;
            pop_pass_reg    <= '0;
            outstanding_reg <= '0;
            mem_address0    <= '0;
            mem_ce0         <= 1'b0;
            mem_we0         <= 1'b0;
            mem_d0          <= '0;
        end else begin
            mem_ce0 <= 1'b0;
            mem_we0 <= 1'b0;
            if (start_ok) begin
                n_reg        <= n_sat;
                passes_reg   <= (num_passes == 16'd0) ? 16'd1 : num_passes;
                wr_cnt_reg   <= '0;
                rd_addr_reg  <= '0;
                rd_pass_reg  <= '0;
                pop_idx_reg  <= '0;
                pop_pass_reg <= '0;
            end
            if (wr_fire) begin
                mem_ce0      <= 1'b1;
                mem_we0      <= 1'b1;
                mem_address0 <= wr_cnt_reg[AddressWidth-1:0];
                mem_d0       <= in_data;
                wr_cnt_reg   <= wr_cnt_reg + CountWidth'(1);
            end
            if (rd_fire) begin
                mem_ce0      <= 1'b1;
                mem_address0 <= rd_addr_reg;
                rd_addr_reg  <= rd_wrap ? '0 : rd_addr_reg + AddressWidth'(1);
                if (rd_wrap) begin
                    rd_pass_reg <= rd_pass_reg + 16'd1;
                end
            end
            if (pop) begin
                pop_idx_reg <= pop_wrap ? '0 : pop_idx_reg + AddressWidth'(1);
                if (pop_wrap) begin
                    pop_pass_reg <= pop_pass_reg + 16'd1;
                end
            end
            outstanding_reg <= outstanding_reg + FillWidth'(rd_fire) - FillWidth'(push);
        end
    end

endmodule

// File: tb/tb_knn_local_sp_stream_ctrl.sv
// Directed bench for the local search-point buffer controller, paired with
// a behavioural single-port buffer model with one cycle of read latency.
module tb_knn_local_sp_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [11:0]  num_words;
    logic [15:0]  num_passes;
    logic         busy;
    logic         done;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [10:0]  mem_address0;
    logic         mem_ce0;
    logic         mem_we0;
    logic [255:0] mem_d0;
    logic [255:0] mem_q0;

    knn_local_sp_stream_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_words    (num_words),
        .num_passes   (num_passes),
        .busy         (busy),
        .done         (done),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_address0 (mem_address0),
        .mem_ce0      (mem_ce0),
        .mem_we0      (mem_we0),
        .mem_d0       (mem_d0),
        .mem_q0       (mem_q0)
    );

    always #5 clk = ~clk;

    // Behavioural buffer: one-cycle registered read, write-only on we
    logic [255:0] model_mem [0:2047];
    logic [255:0] model_q = '0;
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) model_mem[mem_address0] <= mem_d0;
            else         model_q <= model_mem[mem_address0];
        end
    end
    assign mem_q0 = model_q;

    int checks = 0;
    int errors = 0;
    logic [255:0] src [0:2047];
    int n_eff, total, cyc, in_idx, wr_seen, rd_seen, pop_seen, wraps;
    int done_cnt, done_seen, ce_cnt, ready_cnt, over_ready, busy_after;
    int start_cyc, done_cyc, last_in_cyc, first_pop_cyc, last_pop_cyc;
    int out_mode;
    bit kick, gap_mode, inject;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},      256'(busy),         256'(0));
        check_val({tag, "_done"},      256'(done),         256'(0));
        check_val({tag, "_in_ready"},  256'(in_ready),     256'(0));
        check_val({tag, "_out_valid"}, 256'(out_valid),    256'(0));
        check_val({tag, "_ce0"},       256'(mem_ce0),      256'(0));
        check_val({tag, "_we0"},       256'(mem_we0),      256'(0));
        check_val({tag, "_addr0"},     256'(mem_address0), 256'(0));
        check_val({tag, "_d0"},        mem_d0,             256'(0));
        check_val({tag, "_out_data"},  out_data,           256'(0));
    endtask

    task automatic setup_test(input int n_req, input int p_req, input int base, input int salt);
        n_eff = (n_req > 2048) ? 2048 : n_req;
        total = n_eff * ((p_req == 0) ? 1 : p_req);
        for (int i = 0; i < 2048; i++) src[i] = (256'(salt) << 128) | 256'(base + i);
        cyc = 0; in_idx = 0; wr_seen = 0; rd_seen = 0; pop_seen = 0; wraps = 0;
        done_cnt = 0; done_seen = 0; ce_cnt = 0; ready_cnt = 0; over_ready = 0; busy_after = 0;
        start_cyc = 0; done_cyc = 0; last_in_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;
        num_words = 12'(n_req);
        num_passes = 16'(p_req);
        kick = 1'b1;
    endtask

    // One clock: observe registered outputs, drive inputs, account handshakes
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_ce0 && mem_we0) begin
            check_val("wr_addr", 256'(mem_address0), 256'(wr_seen));
            check_val("wr_data", mem_d0, (wr_seen < 2048) ? src[wr_seen] : 256'(0));
            wr_seen++;
        end
        if (mem_ce0 && !mem_we0) begin
            check_val("rd_addr", 256'(mem_address0), 256'((n_eff == 0) ? 0 : rd_seen % n_eff));
            if (rd_seen > 0 && mem_address0 == 11'd0) wraps++;
            rd_seen++;
        end
        if (mem_we0) check_val("we_needs_ce", 256'(mem_ce0), 256'(1));
        if (mem_ce0) ce_cnt++;
        if (in_ready) ready_cnt++;
        if (in_ready && in_idx >= n_eff) over_ready++;
        if (done_seen != 0 && busy) busy_after++;
        if (done) begin
            done_cnt++;
            check_val("done_busy", 256'(busy), 256'(0));
            check_val("done_pops", 256'(pop_seen), 256'(total));
            done_seen = 1;
            done_cyc = cyc;
        end
        start = kick;
        if (kick) start_cyc = cyc;
        kick = 1'b0;
        in_valid = (in_idx < n_eff) && (!gap_mode || ($urandom_range(2) != 0));
        in_data = (in_idx < 2048) ? src[in_idx] : 256'(0);
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(1) == 1);
            default: out_ready = 1'b0;
        endcase
        if (inject && cyc == 6) begin
            start = 1'b1;
            num_words = 12'd3;
        end
        if (inject && done) begin
            start = 1'b1;
            num_words = 12'd5;
        end
        if (in_valid && in_ready) begin
            in_idx++;
            last_in_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            check_val("out_data", out_data, (n_eff == 0) ? 256'(0) : src[pop_seen % n_eff]);
            if (pop_seen == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_seen++;
        end
    endtask

    task automatic run_test(input string tag, input int budget);
        while (done_seen == 0 && cyc < budget) step();
        check_val({tag, "_timeout"}, 256'(done_seen), 256'(1));
        repeat (3) step();
        check_val({tag, "_done_cnt"},   256'(done_cnt),   256'(1));
        check_val({tag, "_writes"},     256'(wr_seen),    256'(n_eff));
        check_val({tag, "_inputs"},     256'(in_idx),     256'(n_eff));
        check_val({tag, "_reads"},      256'(rd_seen),    256'(total));
        check_val({tag, "_pops"},       256'(pop_seen),   256'(total));
        check_val({tag, "_over_ready"}, 256'(over_ready), 256'(0));
        check_val({tag, "_busy_after"}, 256'(busy_after), 256'(0));
        $display("test %s: n=%0d outputs=%0d cycles=%0d", tag, n_eff, pop_seen, cyc);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_words = '0; num_passes = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        kick = 1'b0; gap_mode = 1'b0; inject = 1'b0; out_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        // Eight words, one pass, no stalls: back-to-back output and fixed latency
        setup_test(8, 1, 'h10, 0);
        run_test("basic8", 200);
        check_val("basic8_first_latency", 256'(first_pop_cyc - last_in_cyc), 256'(4));
        check_val("basic8_back_to_back",  256'(last_pop_cyc - first_pop_cyc), 256'(7));

        // Full buffer, three passes, random backpressure
        setup_test(2048, 3, 'h1000, 2);
        out_mode = 1;
        run_test("full3", 30000);
        check_val("full3_wraps", 256'(wraps), 256'(2));

        // Empty job: done the cycle after start, buffer untouched
        setup_test(0, 1, 0, 3);
        out_mode = 0;
        run_test("empty", 50);
        check_val("empty_done_delay", 256'(done_cyc - start_cyc), 256'(1));
        check_val("empty_ce_cnt",     256'(ce_cnt),    256'(0));
        check_val("empty_ready_cnt",  256'(ready_cnt), 256'(0));

        // Oversized request saturates to the buffer depth; zero passes means one
        setup_test(3000, 0, 'h4000, 4);
        run_test("saturate", 8000);

        // Stall the drain completely, then reset in the middle of it
        setup_test(16, 2, 'h500, 5);
        out_mode = 2;
        for (int i = 0; i < 40; i++) step();
        check_val("stall_credit_reads", 256'(rd_seen), 256'(4));
        check_val("stall_out_valid",    256'(out_valid), 256'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        reset = 1'b0;
        setup_test(4, 1, 'h600, 6);
        out_mode = 0;
        run_test("post_reset", 200);

        // Input gaps, random backpressure, stray start pulses while busy and in DONE
        setup_test(12, 2, 'h700, 7);
        gap_mode = 1'b1;
        out_mode = 1;
        inject = 1'b1;
        run_test("gaps_inject", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
